stack_datapath: RTL and testbench
=================================

// Module: stack_datapath
// PURPOSE
//  LIFO operand stack with integrated ALU; sits directly downstream of the control unit and consumes its
//  push/pop/alu_op decode plus the instruction immediate. Executes one stack operation per accepted beat,
//  exposes top-of-stack and popped data, and halts on stack faults until explicitly cleared.
// PARAMETERS
//  DATA_W  32  width of a stack entry, immediate and ALU result
//  DEPTH   16  number of stack entries (power of 2, >= 4); SP_W = $clog2(DEPTH)+1
// PORTS
//  clock      in   1       single clock; all state updates on posedge
//  reset      in   1       synchronous, active-high
//  op_valid   in   1       decoded operation present this cycle
//  op_ready   out  1       block can accept; low while HALT
//  push       in   1       push imm onto stack
//  pop        in   1       pop top of stack to pop_data
//  alu_op     in   4       ALU operation code (0 = none)
//  imm        in   DATA_W  value pushed by push
//  pop_data   out  DATA_W  value removed by last pop
//  pop_valid  out  1       one-cycle pulse: pop_data updated
//  tos        out  DATA_W  current top of stack (0 when empty)
//  depth      out  SP_W    number of valid entries
//  empty      out  1       depth == 0
//  full       out  1       depth == DEPTH
//  err        out  1       high while in HALT
//  err_code   out  2       0 none, 1 overflow, 2 underflow, 3 illegal op
//  err_clr    in   1       HALT -> RUN, clears err/err_code; stack contents kept
// BEHAVIOUR
//  - Reset: depth=0, pop_data=0, pop_valid=0, err=0, err_code=0, state RUN, op_ready=1; entries undefined.
//  - Accept = op_valid & op_ready. Exactly one of {push, pop, alu_op!=0} legal per beat; zero or >1 -> illegal.
//  - push: mem[depth]<=imm, depth+1. Full -> overflow, no write.
//  - pop: pop_data<=mem[depth-1], pop_valid=1 next cycle, depth-1. Empty -> underflow, pop_valid stays 0.
//  - ALU: A=mem[depth-2], B=mem[depth-1]; mem[depth-2]<=A op B; depth-1. depth<2 -> underflow, no change.
//    3 ADD A+B, 4 OR A|B, 5 SUB A-B, 6 SLT signed(A<B)?1:0, 7 NOR ~(A|B); mod 2^DATA_W, no carry out.
//    Other nonzero codes -> illegal.
//  - Latency: effect visible on tos/depth/empty/full the cycle after accept; back-to-back accepts allowed.
//  - FSM RUN/HALT: any fault in RUN -> HALT next cycle, err_code latched, stack unchanged, op_ready=0.
//    HALT: op_valid ignored; err_clr -> RUN next cycle. err_clr in RUN is a no-op.
//    err_clr and a faulting op in the same cycle cannot coincide (op_ready=0 in HALT).
//  - reset mid-operation overrides everything: state returns to reset values the next cycle.
// CONFIGURATION
//  STACK_DUP_EN defined: alu_op 4'h8 = DUP, pushes copy of tos; empty -> underflow, full -> overflow.
//  STACK_DUP_EN undefined: 4'h8 is an illegal op (err_code 3).
// STRUCTURE
//  stack_pkg: ALU op constants (ALU_ADD..ALU_NOR, ALU_DUP), err_code constants, state enum.
//  Sub-module stack_alu: combinational A op B -> result; datapath owns storage, pointer, FSM.
// TESTING
//  push 5, push 7, ALU 3 -> tos=12, depth=1; then ALU 5 with depth 1 -> err_code=2, depth stays 1.
//  push 3, push 10, ALU 5 -> tos=0xFFFF_FFF9; push -1, push 2, ALU 6 -> tos=1.
//  DEPTH pushes then push 0xAA -> full=1, err_code=1, op_ready=0; err_clr -> op_ready=1, tos unchanged.
//  pop on empty -> err_code=2, pop_valid=0; push 0x1234, pop -> pop_valid pulse, pop_data=0x1234, empty=1.
//  push+pop asserted together, or alu_op=4'hF -> err_code=3; alu_op=8 illegal unless STACK_DUP_EN (then tos duplicated).
//  reset asserted in HALT with depth=4 -> next cycle depth=0, err=0, op_ready=1.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants for the operand stack: ALU opcodes, fault codes and the RUN/HALT state type.
package stack_pkg;

    localparam logic [3:0] ALU_NONE = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h3;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_SUB  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_NOR  = 4'h7;
    localparam logic [3:0] ALU_DUP  = 4'h8;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Binary ops that consume two entries and leave one.
    function automatic logic is_binary_op(input logic [3:0] op);
        return (op >= ALU_ADD) && (op <= ALU_NOR);
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational two-operand ALU: result = a op b, wrapping modulo 2^DATA_W.
module stack_alu
    import stack_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_OR:  result = a | b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stack_datapath.sv
// LIFO operand stack with integrated ALU and RUN/HALT fault handling.
// Define STACK_DUP_EN to make alu_op 4'h8 duplicate the top of stack; otherwise it is illegal.
module stack_datapath
    import stack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic                     push,
    input  logic                     pop,
    input  logic [3:0]               alu_op,
    input  logic [DATA_W-1:0]        imm,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     pop_valid,
    output logic [DATA_W-1:0]        tos,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     err,
    output logic [1:0]               err_code,
    input  logic                     err_clr
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_reg, state_next;
    logic [SP_W-1:0]   depth_reg, depth_next;
    logic [DATA_W-1:0] pop_data_reg;
    logic              pop_valid_reg;
    logic [1:0]        err_code_reg;

    logic [AW-1:0]     top_idx, nos_idx, wr_idx;
    logic [DATA_W-1:0] tos_val, nos_val, alu_result;
    logic [1:0]        op_cnt;
    logic [1:0]        fault_code;
    logic              fault, accept;
    logic              do_push, do_pop, do_alu, do_dup;

    assign top_idx = depth_reg[AW-1:0] - AW'(1);
    assign nos_idx = depth_reg[AW-1:0] - AW'(2);
    assign wr_idx  = depth_reg[AW-1:0];
    assign tos_val = mem[top_idx];
    assign nos_val = mem[nos_idx];

    assign empty = (depth_reg == '0);
    assign full  = (depth_reg == SP_W'(DEPTH));

    stack_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (alu_op),
        .a      (nos_val),
        .b      (tos_val),
        .result (alu_result)
    );

    assign accept = op_valid & op_ready;
    assign op_cnt = {1'b0, push} + {1'b0, pop} + {1'b0, |alu_op};

    // Decode; the do_* strobes are only set for operations that will not fault.
    always_comb begin
        fault_code = ERR_NONE;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_alu     = 1'b0;
        do_dup     = 1'b0;
        if (op_cnt != 2'd1) begin
            fault_code = ERR_ILLEGAL;
        end else if (push) begin
            if (full) fault_code = ERR_OVERFLOW;
            else      do_push    = 1'b1;
        end else if (pop) begin
            if (empty) fault_code = ERR_UNDERFLOW;
            else       do_pop     = 1'b1;
        end else if (is_binary_op(alu_op)) begin
            if (depth_reg < SP_W'(2)) fault_code = ERR_UNDERFLOW;
            else                      do_alu     = 1'b1;
`ifdef STACK_DUP_EN
        end else if (alu_op == ALU_DUP) begin
            if (empty)     fault_code = ERR_UNDERFLOW;
            else if (full) fault_code = ERR_OVERFLOW;
            else           do_dup     = 1'b1;
`endif
        end else begin
            fault_code = ERR_ILLEGAL;
        end
    end

    assign fault = (fault_code != ERR_NONE);

    always_ff @(posedge clock) begin
        if (reset) state_reg <= ST_RUN;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:  if (accept && fault) state_next = ST_HALT;
            ST_HALT: if (err_clr)         state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        op_ready = 1'b1;
        err      = 1'b0;
        if (state_reg == ST_HALT) begin
            op_ready = 1'b0;
            err      = 1'b1;
        end
    end

    always_comb begin
        depth_next = depth_reg;
        if (accept) begin
            if (do_push || do_dup)     depth_next = depth_reg + SP_W'(1);
            else if (do_pop || do_alu) depth_next = depth_reg - SP_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            depth_reg     <= '0;
            pop_data_reg  <= '0;
            pop_valid_reg <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            depth_reg     <= depth_next;
            pop_valid_reg <= accept && do_pop;
            if (accept && do_pop)
                pop_data_reg <= tos_val;
            if (accept && fault)
                err_code_reg <= fault_code;
            else if (state_reg == ST_HALT && err_clr)
                err_code_reg <= ERR_NONE;
        end
    end

    // Storage carries no reset so it maps onto RAM; contents are meaningless above depth_reg.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            if (do_push)     mem[wr_idx]  <= imm;
            else if (do_dup) mem[wr_idx]  <= tos_val;
            else if (do_alu) mem[nos_idx] <= alu_result;
        end
    end

    assign depth     = depth_reg;
    assign tos       = empty ? '0 : tos_val;
    assign pop_data  = pop_data_reg;
    assign pop_valid = pop_valid_reg;
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_stack_datapath.sv
// Self-checking bench for stack_datapath: directed scenarios then random traffic against a queue model.
module tb_stack_datapath;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int SP_W   = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic [3:0]        alu_op = 4'h0;
    logic [DATA_W-1:0] imm = '0;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic [DATA_W-1:0] tos;
    logic [SP_W-1:0]   depth;
    logic              empty;
    logic              full;
    logic              err;
    logic [1:0]        err_code;
    logic              err_clr = 1'b0;

    always #5 clock = ~clock;

    stack_datapath #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .push      (push),
        .pop       (pop),
        .alu_op    (alu_op),
        .imm       (imm),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .tos       (tos),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .err       (err),
        .err_code  (err_code),
        .err_clr   (err_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the stack is a queue whose back is the top of stack.
    logic [DATA_W-1:0] model_stk[$];
    logic              model_halt      = 1'b0;
    logic [1:0]        model_code      = 2'd0;
    logic [DATA_W-1:0] model_pop_data  = '0;
    logic              model_pop_valid = 1'b0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] alu_ref(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (op)
            4'd3:    return a + b;
            4'd4:    return a | b;
            4'd5:    return a - b;
            4'd6:    return ($signed(a) < $signed(b)) ? DATA_W'(1) : DATA_W'(0);
            default: return ~(a | b);
        endcase
    endfunction

    task automatic model_fault(input logic [1:0] code);
        model_halt = 1'b1;
        model_code = code;
    endtask

    task automatic model_op(input logic p, input logic q, input logic [3:0] a, input logic [DATA_W-1:0] v);
        int n;
        logic [DATA_W-1:0] x, y;
        model_pop_valid = 1'b0;
        if (model_halt) return;
        n = int'(p) + int'(q) + ((a != 4'h0) ? 1 : 0);
        if (n != 1) begin
            model_fault(2'd3);
        end else if (p) begin
            if (model_stk.size() == DEPTH) model_fault(2'd1);
            else model_stk.push_back(v);
        end else if (q) begin
            if (model_stk.size() == 0) model_fault(2'd2);
            else begin
                model_pop_data  = model_stk.pop_back();
                model_pop_valid = 1'b1;
            end
        end else if (a >= 4'd3 && a <= 4'd7) begin
            if (model_stk.size() < 2) model_fault(2'd2);
            else begin
                y = model_stk.pop_back();
                x = model_stk.pop_back();
                model_stk.push_back(alu_ref(a, x, y));
            end
`ifdef STACK_DUP_EN
        end else if (a == 4'h8) begin
            if (model_stk.size() == 0) model_fault(2'd2);
            else if (model_stk.size() == DEPTH) model_fault(2'd1);
            else model_stk.push_back(model_stk[$]);
`endif
        end else begin
            model_fault(2'd3);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] exp_tos;
        exp_tos = (model_stk.size() == 0) ? '0 : model_stk[$];
        $display("[%0t] %s depth=%0d tos=0x%08h err=%0d code=%0d pv=%0d pd=0x%08h",
                 $time, tag, depth, tos, err, err_code, pop_valid, pop_data);
        chk({tag, ".tos"},       tos, exp_tos);
        chk({tag, ".depth"},     DATA_W'(depth), DATA_W'(model_stk.size()));
        chk({tag, ".empty"},     DATA_W'(empty), DATA_W'(model_stk.size() == 0));
        chk({tag, ".full"},      DATA_W'(full), DATA_W'(model_stk.size() == DEPTH));
        chk({tag, ".err"},       DATA_W'(err), DATA_W'(model_halt));
        chk({tag, ".err_code"},  DATA_W'(err_code), DATA_W'(model_code));
        chk({tag, ".op_ready"},  DATA_W'(op_ready), DATA_W'(!model_halt));
        chk({tag, ".pop_valid"}, DATA_W'(pop_valid), DATA_W'(model_pop_valid));
        chk({tag, ".pop_data"},  pop_data, model_pop_data);
    endtask

    task automatic step(input string tag, input logic p, input logic q, input logic [3:0] a,
                        input logic [DATA_W-1:0] v);
        op_valid = 1'b1;
        push     = p;
        pop      = q;
        alu_op   = a;
        imm      = v;
        @(posedge clock);
        #1;
        model_op(p, q, a, v);
        op_valid = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        alu_op   = 4'h0;
        check_all(tag);
    endtask

    task automatic do_push(input string tag, input logic [DATA_W-1:0] v);
        step(tag, 1'b1, 1'b0, 4'h0, v);
    endtask

    task automatic do_idle(input string tag);
        @(posedge clock);
        #1;
        model_pop_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic do_clear(input string tag);
        err_clr = 1'b1;
        @(posedge clock);
        #1;
        err_clr = 1'b0;
        model_pop_valid = 1'b0;
        if (model_halt) begin
            model_halt = 1'b0;
            model_code = 2'd0;
        end
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_stk.delete();
        model_halt      = 1'b0;
        model_code      = 2'd0;
        model_pop_data  = '0;
        model_pop_valid = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [DATA_W-1:0] last_val;
        logic [3:0]        rop;
        int                r;

        do_reset("reset");
        chk("reset_op_ready", DATA_W'(op_ready), DATA_W'(1));

        // Add, then a binary op with only one operand.
        do_push("push5", 32'd5);
        do_push("push7", 32'd7);
        step("add", 1'b0, 1'b0, 4'd3, '0);
        chk("add_result", tos, 32'd12);
        step("sub_underflow", 1'b0, 1'b0, 4'd5, '0);
        chk("sub_uf_code", DATA_W'(err_code), DATA_W'(2));
        chk("sub_uf_depth", DATA_W'(depth), DATA_W'(1));
        do_clear("clr1");

        do_push("push3", 32'd3);
        do_push("push10", 32'd10);
        step("sub", 1'b0, 1'b0, 4'd5, '0);
        chk("sub_result", tos, 32'hFFFF_FFF9);
        do_push("push_m1", 32'hFFFF_FFFF);
        do_push("push2", 32'd2);
        step("slt", 1'b0, 1'b0, 4'd6, '0);
        chk("slt_result", tos, 32'd1);
        do_push("push_or", 32'h0000_00F0);
        step("or", 1'b0, 1'b0, 4'd4, '0);
        do_push("push_nor", 32'h0F0F_0000);
        step("nor", 1'b0, 1'b0, 4'd7, '0);

        // Fill to capacity then overflow.
        do_reset("reset2");
        for (int i = 0; i < DEPTH; i++) begin
            last_val = $urandom;
            do_push("fill", last_val);
        end
        step("overflow", 1'b1, 1'b0, 4'h0, 32'hAA);
        chk("ovf_full", DATA_W'(full), DATA_W'(1));
        chk("ovf_code", DATA_W'(err_code), DATA_W'(1));
        chk("ovf_ready", DATA_W'(op_ready), DATA_W'(0));
        step("halt_ignored", 1'b0, 1'b1, 4'h0, '0);
        do_clear("clr_ovf");
        chk("clr_ready", DATA_W'(op_ready), DATA_W'(1));
        chk("clr_tos", tos, last_val);
        do_clear("clr_in_run");

        // Pop behaviour.
        do_reset("reset3");
        step("pop_empty", 1'b0, 1'b1, 4'h0, '0);
        chk("pop_uf_code", DATA_W'(err_code), DATA_W'(2));
        chk("pop_uf_pv", DATA_W'(pop_valid), DATA_W'(0));
        do_clear("clr_pop");
        do_push("push1234", 32'h1234);
        step("pop", 1'b0, 1'b1, 4'h0, '0);
        chk("pop_pv", DATA_W'(pop_valid), DATA_W'(1));
        chk("pop_data", pop_data, 32'h1234);
        chk("pop_empty_flag", DATA_W'(empty), DATA_W'(1));
        do_idle("pop_pulse_end");

        // Illegal encodings.
        do_push("push_a", 32'h55);
        step("push_and_pop", 1'b1, 1'b1, 4'h0, 32'h66);
        chk("pp_code", DATA_W'(err_code), DATA_W'(3));
        do_clear("clr_pp");
        step("no_op", 1'b0, 1'b0, 4'h0, '0);
        do_clear("clr_noop");
        step("alu_f", 1'b0, 1'b0, 4'hF, '0);
        chk("f_code", DATA_W'(err_code), DATA_W'(3));
        do_clear("clr_f");
        step("alu_8", 1'b0, 1'b0, 4'h8, '0);
`ifdef STACK_DUP_EN
        chk("dup_tos", tos, 32'h55);
        chk("dup_depth", DATA_W'(depth), DATA_W'(2));
`else
        chk("op8_code", DATA_W'(err_code), DATA_W'(3));
`endif
        do_clear("clr_8");

        // Reset while halted with four entries.
        do_reset("reset4");
        for (int i = 0; i < 4; i++) do_push("push4", $urandom);
        step("halt_d4", 1'b0, 1'b0, 4'h2, '0);
        do_reset("reset_in_halt");
        chk("rh_depth", DATA_W'(depth), DATA_W'(0));
        chk("rh_err", DATA_W'(err), DATA_W'(0));
        chk("rh_ready", DATA_W'(op_ready), DATA_W'(1));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 11);
            if (model_halt && r < 7) begin
                do_clear("rnd_clr");
            end else if (r < 4) begin
                do_push("rnd_push", $urandom);
            end else if (r < 6) begin
                step("rnd_pop", 1'b0, 1'b1, 4'h0, '0);
            end else if (r < 9) begin
                rop = 4'($urandom_range(3, 7));
                step("rnd_alu", 1'b0, 1'b0, rop, '0);
            end else if (r < 10) begin
                do_idle("rnd_idle");
            end else begin
                rop = 4'($urandom_range(0, 15));
                step("rnd_any", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rop, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
